// File: rtl/apu_sound_scheduler.sv
// rtl/apu_sound_scheduler.sv - fixed-priority scheduler for the single APU tone channel
module apu_sound_scheduler #(
    parameter int NOTE_FRAMES = 4,
    parameter int NOTES       = 3,
    parameter int GAP_FRAMES  = 1,
    parameter int PREEMPT     = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       frame_end,
    input  logic       eat_trig,
    input  logic       hit_trig,
    input  logic       die_trig,
    output logic       sound_on,
    output logic [1:0] sound_id,
    output logic [1:0] note_idx,
    output logic       sound_start,
    output logic [2:0] pending
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_FRAME = 4'(NOTE_FRAMES - 1);
    localparam logic [1:0] LAST_NOTE  = 2'(NOTES - 1);
    localparam logic [1:0] LAST_GAP   = 2'((GAP_FRAMES > 0) ? (GAP_FRAMES - 1) : 0);

    state_t     state, state_n;
    logic [2:0] trig_now, trig_q, rise;
    logic [2:0] pend_r, pend_n, clr;
    logic [3:0] frame_cnt, frame_cnt_n;
    logic [1:0] gap_cnt, gap_cnt_n;
    logic [1:0] note_r, note_n;
    logic [1:0] id_r, id_n;
    logic       on_r, on_n;
    logic       start_r, start_n;
    logic [1:0] top_id;
    logic [2:0] top_mask;

    assign trig_now = {die_trig, hit_trig, eat_trig};
    assign rise     = trig_now & ~trig_q;

    // Bit index + 1 doubles as the sound id, so priority compares are plain magnitude compares.
    always_comb begin
        top_id   = 2'd0;
        top_mask = 3'b000;
        if (pend_r[2]) begin
            top_id   = 2'd3;
            top_mask = 3'b100;
        end else if (pend_r[1]) begin
            top_id   = 2'd2;
            top_mask = 3'b010;
        end else if (pend_r[0]) begin
            top_id   = 2'd1;
            top_mask = 3'b001;
        end
    end

    always_comb begin
        state_n     = state;
        frame_cnt_n = frame_cnt;
        gap_cnt_n   = gap_cnt;
        note_n      = note_r;
        id_n        = id_r;
        on_n        = on_r;
        start_n     = 1'b0;
        clr         = 3'b000;

        case (state)
            IDLE: begin
                if (top_id != 2'd0) begin
                    state_n     = PLAY;
                    on_n        = 1'b1;
                    id_n        = top_id;
                    note_n      = 2'd0;
                    frame_cnt_n = 4'd0;
                    start_n     = 1'b1;
                    clr         = top_mask;
                end
            end
            PLAY: begin
                if ((PREEMPT != 0) && (top_id > id_r)) begin
                    on_n        = 1'b1;
                    id_n        = top_id;
                    note_n      = 2'd0;
                    frame_cnt_n = 4'd0;
                    start_n     = 1'b1;
                    clr         = top_mask;
                end else if (frame_end) begin
                    if (frame_cnt >= LAST_FRAME) begin
                        frame_cnt_n = 4'd0;
                        if (note_r >= LAST_NOTE) begin
                            on_n      = 1'b0;
                            id_n      = 2'd0;
                            note_n    = 2'd0;
                            gap_cnt_n = 2'd0;
                            state_n   = (GAP_FRAMES > 0) ? GAP : IDLE;
                        end else begin
                            note_n = note_r + 2'd1;
                        end
                    end else begin
                        frame_cnt_n = frame_cnt + 4'd1;
                    end
                end
            end
            GAP: begin
                if (frame_end) begin
                    if (gap_cnt >= LAST_GAP) begin
                        gap_cnt_n = 2'd0;
                        state_n   = IDLE;
                    end else begin
                        gap_cnt_n = gap_cnt + 2'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // A new edge beats a same-cycle grant clear, so the sound replays later.
        pend_n = (pend_r & ~clr) | rise;

        if (!enable) begin
            state_n     = IDLE;
            frame_cnt_n = 4'd0;
            gap_cnt_n   = 2'd0;
            note_n      = 2'd0;
            id_n        = 2'd0;
            on_n        = 1'b0;
            start_n     = 1'b0;
            pend_n      = 3'b000;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            trig_q    <= 3'b000;
            pend_r    <= 3'b000;
            frame_cnt <= 4'd0;
            gap_cnt   <= 2'd0;
            note_r    <= 2'd0;
            id_r      <= 2'd0;
            on_r      <= 1'b0;
            start_r   <= 1'b0;
        end else begin
            state     <= state_n;
            trig_q    <= trig_now;
            pend_r    <= pend_n;
            frame_cnt <= frame_cnt_n;
            gap_cnt   <= gap_cnt_n;
            note_r    <= note_n;
            id_r      <= id_n;
            on_r      <= on_n;
            start_r   <= start_n;
        end
    end

    assign sound_on    = on_r;
    assign sound_id    = id_r;
    assign note_idx    = note_r;
    assign sound_start = start_r;
    assign pending     = pend_r;

endmodule

// File: tb/tb_apu_sound_scheduler.sv
// tb/tb_apu_sound_scheduler.sv - directed scoreboard bench for apu_sound_scheduler
module tb_apu_sound_scheduler;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       frame_end;
    logic       eat_trig;
    logic       hit_trig;
    logic       die_trig;
    logic       sound_on;
    logic [1:0] sound_id;
    logic [1:0] note_idx;
    logic       sound_start;
    logic [2:0] pending;

    int         checks;
    int         errors;
    int         starts;
    int         s0;
    logic [1:0] exp_q[$];
    logic [1:0] sb_exp;

    apu_sound_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .frame_end  (frame_end),
        .eat_trig   (eat_trig),
        .hit_trig   (hit_trig),
        .die_trig   (die_trig),
        .sound_on   (sound_on),
        .sound_id   (sound_id),
        .note_idx   (note_idx),
        .sound_start(sound_start),
        .pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_end = 1'b1;
            tick();
            frame_end = 1'b0;
            tick();
        end
    endtask

    // Every grant must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (sound_start) begin
            starts++;
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_start", {2'b00, sound_id}, 4'h0);
            end else begin
                sb_exp = exp_q.pop_front();
                chk("sb_sound_id", {2'b00, sound_id}, {2'b00, sb_exp});
            end
        end
    end

    initial begin
        checks    = 0;
        errors    = 0;
        starts    = 0;
        reset     = 1'b0;
        enable    = 1'b1;
        frame_end = 1'b0;
        eat_trig  = 1'b0;
        hit_trig  = 1'b0;
        die_trig  = 1'b0;
        tick();
        tick();
        chk("rst_sound_on", {3'b0, sound_on}, 4'h0);
        chk("rst_sound_id", {2'b0, sound_id}, 4'h0);
        chk("rst_pending", {1'b0, pending}, 4'h0);
        reset = 1'b1;
        tick();

        // eat alone: latency and note stepping
        eat_trig = 1'b1;
        exp_q.push_back(2'd1);
        tick();
        chk("t1_pending", {1'b0, pending}, 4'b0001);
        chk("t1_on_early", {3'b0, sound_on}, 4'h0);
        tick();
        chk("t1_on", {3'b0, sound_on}, 4'h1);
        chk("t1_id", {2'b0, sound_id}, 4'h1);
        chk("t1_start", {3'b0, sound_start}, 4'h1);
        chk("t1_note0", {2'b0, note_idx}, 4'h0);
        chk("t1_pend_clr", {1'b0, pending}, 4'h0);
        eat_trig = 1'b0;
        tick();
        chk("t1_start_pulse", {3'b0, sound_start}, 4'h0);
        frames(4);
        chk("t1_note1", {2'b0, note_idx}, 4'h1);
        frames(7);
        chk("t1_note2", {2'b0, note_idx}, 4'h2);
        chk("t1_on_f11", {3'b0, sound_on}, 4'h1);
        frames(1);
        chk("t1_off", {3'b0, sound_on}, 4'h0);
        chk("t1_off_id", {2'b0, sound_id}, 4'h0);
        chk("t1_off_note", {2'b0, note_idx}, 4'h0);
        frames(1);

        // hit preempts eat; eat is dropped
        eat_trig = 1'b1;
        exp_q.push_back(2'd1);
        tick();
        tick();
        eat_trig = 1'b0;
        frames(2);
        hit_trig = 1'b1;
        exp_q.push_back(2'd2);
        tick();
        chk("t2_pending", {1'b0, pending}, 4'b0010);
        chk("t2_id_before", {2'b0, sound_id}, 4'h1);
        tick();
        chk("t2_id", {2'b0, sound_id}, 4'h2);
        chk("t2_start", {3'b0, sound_start}, 4'h1);
        chk("t2_note", {2'b0, note_idx}, 4'h0);
        hit_trig = 1'b0;
        frames(12);
        chk("t2_off", {3'b0, sound_on}, 4'h0);
        chk("t2_pending_end", {1'b0, pending}, 4'h0);
        frames(1);
        repeat (5) tick();
        chk("t2_no_resume", {3'b0, sound_on}, 4'h0);

        // simultaneous die + eat: die first, eat after the gap
        die_trig = 1'b1;
        eat_trig = 1'b1;
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd1);
        tick();
        chk("t3_pending", {1'b0, pending}, 4'b0101);
        tick();
        chk("t3_id_die", {2'b0, sound_id}, 4'h3);
        chk("t3_pend_eat", {1'b0, pending}, 4'b0001);
        die_trig = 1'b0;
        eat_trig = 1'b0;
        frames(12);
        chk("t3_gap_silent", {3'b0, sound_on}, 4'h0);
        chk("t3_gap_pend", {1'b0, pending}, 4'b0001);
        frames(1);
        chk("t3_eat_on", {3'b0, sound_on}, 4'h1);
        chk("t3_eat_id", {2'b0, sound_id}, 4'h1);
        frames(13);

        // held hit trigger gives exactly one sound
        s0 = starts;
        hit_trig = 1'b1;
        exp_q.push_back(2'd2);
        frames(100);
        chk("t4_one_start", 4'(starts - s0), 4'h1);
        chk("t4_pending", {1'b0, pending}, 4'h0);
        chk("t4_off", {3'b0, sound_on}, 4'h0);
        hit_trig = 1'b0;
        tick();

        // enable drop with eat pending behind hit
        hit_trig = 1'b1;
        exp_q.push_back(2'd2);
        tick();
        tick();
        hit_trig = 1'b0;
        frames(2);
        eat_trig = 1'b1;
        tick();
        chk("t5_pend_eat", {1'b0, pending}, 4'b0001);
        chk("t5_still_hit", {2'b0, sound_id}, 4'h2);
        enable = 1'b0;
        tick();
        chk("t5_off", {3'b0, sound_on}, 4'h0);
        chk("t5_pend_clr", {1'b0, pending}, 4'h0);
        chk("t5_id_clr", {2'b0, sound_id}, 4'h0);
        eat_trig = 1'b0;
        tick();
        eat_trig = 1'b1;
        tick();
        chk("t5_edge_discard", {1'b0, pending}, 4'h0);
        enable = 1'b1;
        eat_trig = 1'b0;
        repeat (3) tick();
        chk("t5_no_sound", {3'b0, sound_on}, 4'h0);
        eat_trig = 1'b1;
        exp_q.push_back(2'd1);
        tick();
        tick();
        chk("t5_idle_grant", {3'b0, sound_on}, 4'h1);
        eat_trig = 1'b0;
        frames(2);

        // asynchronous reset mid-sound, release with die held high
        #2;
        reset = 1'b0;
        #1;
        chk("t6_on_async", {3'b0, sound_on}, 4'h0);
        chk("t6_id_async", {2'b0, sound_id}, 4'h0);
        chk("t6_note_async", {2'b0, note_idx}, 4'h0);
        chk("t6_pend_async", {1'b0, pending}, 4'h0);
        die_trig = 1'b1;
        tick();
        reset = 1'b1;
        exp_q.push_back(2'd3);
        tick();
        chk("t6_pend_die", {1'b0, pending}, 4'b0100);
        tick();
        chk("t6_die_on", {3'b0, sound_on}, 4'h1);
        chk("t6_die_id", {2'b0, sound_id}, 4'h3);
        die_trig = 1'b0;
        frames(13);
        chk("sb_drained", 4'(exp_q.size()), 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
